// File: rtl/rf_wb_sched.sv
// Regfile write-port scheduler and RAW/WAW scoreboard for the ID stage.
// ALU has write-port priority; the LSU is protected against starvation.
module rf_wb_sched #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 64,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
    input  logic                      issue_use_rs1,
    input  logic                      issue_use_rs2,
    input  logic                      alu_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_wb_addr,
    input  logic [DATA_WIDTH-1:0]     alu_wb_data,
    input  logic                      lsu_wb_valid,
    output logic                      lsu_wb_ready,
    input  logic [REG_ADDR_WIDTH-1:0] lsu_wb_addr,
    input  logic [DATA_WIDTH-1:0]     lsu_wb_data,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    output logic                      stall_id
);

    localparam int NREG = 1 << REG_ADDR_WIDTH;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [3:0]                cnt;
    logic [3:0]                cnt_nxt;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           busy_nxt;
    logic                      lsu_hs;
    logic                      grant;
    logic                      hazard;
    logic                      accept;
    logic                      hold;
    logic [REG_ADDR_WIDTH-1:0] g_addr;
    logic [DATA_WIDTH-1:0]     g_data;

    assign lsu_wb_ready = !alu_wb_valid;
    assign lsu_hs       = lsu_wb_valid && lsu_wb_ready;
    assign grant        = alu_wb_valid || lsu_hs;
    assign g_addr       = alu_wb_valid ? alu_wb_addr : lsu_wb_addr;
    assign g_data       = alu_wb_valid ? alu_wb_data : lsu_wb_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= grant && (g_addr != '0);
            if (grant) begin
                rf_waddr <= g_addr;
                rf_wdata <= g_data;
            end
        end
    end

    assign hazard = issue_valid &&
                    ((issue_use_rs1 && busy[issue_rs1]) ||
                     (issue_use_rs2 && busy[issue_rs2]) ||
                     ((issue_rd != '0) && busy[issue_rd]));
    assign stall_id = hazard || hold;
    assign accept   = issue_valid && !stall_id;

    // Set is applied after clear so a same-edge reissue keeps the bit.
    always_comb begin
        busy_nxt = busy;
        if (rf_we) begin
            busy_nxt[rf_waddr] = 1'b0;
        end
        if (accept && (issue_rd != '0)) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (lsu_wb_valid && !lsu_wb_ready) begin
                    cnt_nxt   = 4'd1;
                    state_nxt = (4'd1 >= LIMIT) ? HOLD : WAIT;
                end
            end
            WAIT: begin
                if (!lsu_wb_valid || lsu_hs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    if (cnt < LIMIT) begin
                        cnt_nxt = cnt + 4'd1;
                    end
                    if (cnt_nxt >= LIMIT) begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!lsu_wb_valid || lsu_hs) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        hold = (state == HOLD);
    end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed bench for rf_wb_sched with a writeback scoreboard.
// Expected regfile writes are queued at grant and matched on rf_we.
module tb_rf_wb_sched;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_addr;
    logic [63:0] alu_wb_data;
    logic        lsu_wb_valid;
    logic        lsu_wb_ready;
    logic [4:0]  lsu_wb_addr;
    logic [63:0] lsu_wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        stall_id;

    int  checks = 0;
    int  failures = 0;
    wr_t q[$];

    always #5 clk = ~clk;

    rf_wb_sched #(
        .REG_ADDR_WIDTH(5),
        .DATA_WIDTH(64),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .issue_valid(issue_valid),
        .issue_rd(issue_rd),
        .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1),
        .issue_use_rs2(issue_use_rs2),
        .alu_wb_valid(alu_wb_valid),
        .alu_wb_addr(alu_wb_addr),
        .alu_wb_data(alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid),
        .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr),
        .lsu_wb_data(lsu_wb_data),
        .rf_we(rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .stall_id(stall_id)
    );

    task automatic chkw(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rf_we === 1'b1) begin
            if (q.size() == 0) begin
                chk1("sb_unexpected_we", rf_we, 1'b0);
            end else begin
                wr_t e;
                e = q.pop_front();
                chkw("sb_waddr", 64'(rf_waddr), 64'(e.addr));
                chkw("sb_wdata", rf_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        issue_valid   = 1'b0;
        issue_rd      = '0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_use_rs1 = 1'b0;
        issue_use_rs2 = 1'b0;
        alu_wb_valid  = 1'b0;
        alu_wb_addr   = '0;
        alu_wb_data   = '0;
        lsu_wb_valid  = 1'b0;
        lsu_wb_addr   = '0;
        lsu_wb_data   = '0;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [63:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (a != 5'd0) q.push_back(e);
    endtask

    task automatic alu(input logic [4:0] a, input logic [63:0] d);
        alu_wb_valid = 1'b1;
        alu_wb_addr  = a;
        alu_wb_data  = d;
        expect_wr(a, d);
    endtask

    task automatic lsu(input logic v, input logic [4:0] a,
                       input logic [63:0] d);
        lsu_wb_valid = v;
        lsu_wb_addr  = a;
        lsu_wb_data  = d;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        issue_valid   = v;
        issue_rd      = rd;
        issue_rs1     = rs1;
        issue_use_rs1 = u1;
        issue_rs2     = rs2;
        issue_use_rs2 = u2;
    endtask

    initial begin
        idle_in();
        #2;
        chk1("rst_we", rf_we, 1'b0);
        chkw("rst_waddr", 64'(rf_waddr), 64'h0);
        chkw("rst_wdata", rf_wdata, 64'h0);
        chk1("rst_stall", stall_id, 1'b0);
        chk1("rst_ready", lsu_wb_ready, 1'b1);
        #10 rst_n = 1'b1;
        tick();

        // RAW on x5 resolved by an ALU write
        issue(1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk1("t1_accept", stall_id, 1'b0);
        tick();
        issue(1'b1, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0);
        alu(5'd5, 64'hAB);
        settle();
        chk1("t1_stall_a", stall_id, 1'b1);
        tick();
        alu_wb_valid = 1'b0;
        settle();
        chk1("t1_stall_b", stall_id, 1'b1);
        chk1("t1_we", rf_we, 1'b1);
        chkw("t1_waddr", 64'(rf_waddr), 64'h5);
        chkw("t1_wdata", rf_wdata, 64'hAB);
        tick();
        settle();
        chk1("t1_release", stall_id, 1'b0);
        tick();
        idle_in();

        // ALU beats LSU, LSU follows
        alu(5'd3, 64'h33);
        lsu(1'b1, 5'd7, 64'h77);
        settle();
        chk1("t2_ready_lo", lsu_wb_ready, 1'b0);
        tick();
        alu_wb_valid = 1'b0;
        settle();
        chk1("t2_ready_hi", lsu_wb_ready, 1'b1);
        chkw("t2_waddr_alu", 64'(rf_waddr), 64'h3);
        expect_wr(5'd7, 64'h77);
        tick();
        lsu(1'b0, 5'd0, 64'h0);
        settle();
        chkw("t2_waddr_lsu", 64'(rf_waddr), 64'h7);
        chkw("t2_wdata_lsu", rf_wdata, 64'h77);
        tick();

        // Starvation: four blocked cycles reach HOLD
        lsu(1'b1, 5'd14, 64'hEE);
        for (int i = 0; i < 4; i++) begin
            alu(5'(10 + i), 64'(256 + i));
            settle();
            chk1("t3_blocked", lsu_wb_ready, 1'b0);
            chk1("t3_no_hold", stall_id, 1'b0);
            tick();
        end
        alu(5'd15, 64'h1F);
        issue(1'b1, 5'd0, 5'd1, 1'b1, 5'd0, 1'b0);
        settle();
        chk1("t3_hold", stall_id, 1'b1);
        chk1("t3_alu_prio", lsu_wb_ready, 1'b0);
        tick();
        alu_wb_valid = 1'b0;
        settle();
        chk1("t3_hold_grant", stall_id, 1'b1);
        chk1("t3_lsu_ready", lsu_wb_ready, 1'b1);
        expect_wr(5'd14, 64'hEE);
        tick();
        lsu(1'b0, 5'd0, 64'h0);
        settle();
        chk1("t3_released", stall_id, 1'b0);
        tick();
        idle_in();

        // x0 destinations
        issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk1("t4_rd0_accept", stall_id, 1'b0);
        tick();
        issue_valid = 1'b0;
        lsu(1'b1, 5'd0, 64'h55);
        settle();
        chk1("t4_x0_ready", lsu_wb_ready, 1'b1);
        tick();
        lsu(1'b0, 5'd0, 64'h0);
        issue(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        settle();
        chk1("t4_x0_no_we", rf_we, 1'b0);
        chkw("t4_x0_waddr", 64'(rf_waddr), 64'h0);
        chkw("t4_x0_wdata", rf_wdata, 64'h55);
        chk1("t4_x0_no_busy", stall_id, 1'b0);
        tick();
        idle_in();

        // Same-edge set and clear on x9
        alu(5'd9, 64'h99);
        tick();
        alu_wb_valid = 1'b0;
        issue(1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk1("t5_we", rf_we, 1'b1);
        chkw("t5_waddr", 64'(rf_waddr), 64'h9);
        chk1("t5_accept", stall_id, 1'b0);
        tick();
        issue(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1);
        settle();
        chk1("t5_set_wins", stall_id, 1'b1);
        tick();
        alu(5'd9, 64'h9A);
        settle();
        chk1("t5_still_a", stall_id, 1'b1);
        tick();
        alu_wb_valid = 1'b0;
        settle();
        chk1("t5_still_b", stall_id, 1'b1);
        tick();
        settle();
        chk1("t5_release", stall_id, 1'b0);
        tick();
        idle_in();

        // Async reset while in HOLD with x4 busy
        issue(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
        settle();
        chk1("t6_accept", stall_id, 1'b0);
        tick();
        issue_valid = 1'b0;
        lsu(1'b1, 5'd21, 64'h21);
        for (int i = 0; i < 4; i++) begin
            alu(5'd20, 64'(8192 + i));
            tick();
        end
        alu(5'd20, 64'h2004);
        settle();
        chk1("t6_hold", stall_id, 1'b1);
        #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        chk1("t6_rst_we", rf_we, 1'b0);
        chkw("t6_rst_waddr", 64'(rf_waddr), 64'h0);
        chkw("t6_rst_wdata", rf_wdata, 64'h0);
        chk1("t6_rst_stall", stall_id, 1'b0);
        chk1("t6_rst_alu_prio", lsu_wb_ready, 1'b0);
        alu_wb_valid = 1'b0;
        lsu(1'b0, 5'd0, 64'h0);
        #1;
        chk1("t6_rst_ready", lsu_wb_ready, 1'b1);
        issue(1'b1, 5'd0, 5'd4, 1'b1, 5'd0, 1'b0);
        #1;
        chk1("t6_busy_clr", stall_id, 1'b0);
        issue_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        lsu(1'b1, 5'd21, 64'h21);
        settle();
        chk1("t6_represent", lsu_wb_ready, 1'b1);
        expect_wr(5'd21, 64'h21);
        tick();
        lsu(1'b0, 5'd0, 64'h0);
        settle();
        chkw("t6_waddr", 64'(rf_waddr), 64'd21);
        chkw("t6_wdata", rf_wdata, 64'h21);
        tick();
        tick();

        chkw("sb_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
